// File: rtl/alu_exec_unit.sv
// Integer ALU / branch-compare execution unit with a small result FIFO that
// drives the ALU CDB port; back-pressures the reservation station via busy.
module alu_exec_unit #(
  parameter int ROB_TAG_W = 5,
  parameter int DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 reset,
  input  logic                 cal_flg,
  input  logic [31:0]          in_Vj,
  input  logic [31:0]          in_Vk,
  input  logic [31:0]          in_imm,
  input  logic [31:0]          in_pc,
  input  logic [3:0]           in_opcode,
  input  logic [ROB_TAG_W-1:0] in_dest,
  output logic                 busy,
  input  logic                 cdb_grant,
  output logic                 run_upd_alu,
  output logic [ROB_TAG_W-1:0] alu_rd,
  output logic [31:0]          alu_res,
  output logic [31:0]          alu_target
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SLL  = 4'd2,  OP_SLT  = 4'd3,
    OP_SLTU = 4'd4,  OP_XOR  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_OR   = 4'd8,  OP_AND  = 4'd9,  OP_BEQ  = 4'd10, OP_BNE  = 4'd11,
    OP_BLT  = 4'd12, OP_BGE  = 4'd13, OP_BLTU = 4'd14, OP_BGEU = 4'd15
  } op_e;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] dest;
    logic [31:0]          res;
    logic [31:0]          target;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             new_entry;
  entry_t             head_entry;
  logic [PTR_W-1:0]   head_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count;
  logic               enq;
  logic               deq;

  logic [4:0]         shamt;
  logic               lt_s;
  logic               lt_u;
  logic               eq;
  logic               is_branch;
  logic [31:0]        res;

  assign shamt     = in_Vk[4:0];
  assign lt_s      = $signed(in_Vj) < $signed(in_Vk);
  assign lt_u      = in_Vj < in_Vk;
  assign eq        = in_Vj == in_Vk;
  assign is_branch = in_opcode >= 4'd10;

  // NOTE: every path assigns res, so the default up front keeps this block latch-free.
  always_comb begin
    res = '0;
    case (op_e'(in_opcode))
      OP_ADD:  res = in_Vj + in_Vk;
      OP_SUB:  res = in_Vj - in_Vk;
      OP_SLL:  res = in_Vj << shamt;
      OP_SLT:  res = {31'b0, lt_s};
      OP_SLTU: res = {31'b0, lt_u};
      OP_XOR:  res = in_Vj ^ in_Vk;
      OP_SRL:  res = in_Vj >> shamt;
      OP_SRA:  res = $unsigned($signed(in_Vj) >>> shamt);
      OP_OR:   res = in_Vj | in_Vk;
      OP_AND:  res = in_Vj & in_Vk;
      OP_BEQ:  res = {31'b0, eq};
      OP_BNE:  res = {31'b0, !eq};
      OP_BLT:  res = {31'b0, lt_s};
      OP_BGE:  res = {31'b0, !lt_s};
      OP_BLTU: res = {31'b0, lt_u};
      OP_BGEU: res = {31'b0, !lt_u};
      default: res = '0;
    endcase
  end

  always_comb begin
    new_entry.dest   = in_dest;
    new_entry.res    = res;
    new_entry.target = is_branch ? (in_pc + in_imm) : (in_pc + 32'd4);
  end

  // busy and run_upd_alu come only from registered count, so neither has a
  // combinational path from cdb_grant or cal_flg.
  assign busy        = (count == CNT_W'(DEPTH));
  assign run_upd_alu = (count != '0);
  assign enq         = cal_flg && !busy && rdy && !reset;
  assign deq         = run_upd_alu && cdb_grant && rdy && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (rdy) begin
      if (reset) begin
        head_ptr <= '0;
        tail_ptr <= '0;
        count    <= '0;
      end else begin
        if (enq) tail_ptr <= tail_ptr + PTR_W'(1);
        if (deq) head_ptr <= head_ptr + PTR_W'(1);
        case ({enq, deq})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the payload array carries no reset; count gates its visibility, so
  // stale contents can never reach the CDB.
  always_ff @(posedge clk) begin
    if (enq) mem[tail_ptr] <= new_entry;
  end

  assign head_entry = mem[head_ptr];
  assign alu_rd     = run_upd_alu ? head_entry.dest   : '0;
  assign alu_res    = run_upd_alu ? head_entry.res    : '0;
  assign alu_target = run_upd_alu ? head_entry.target : '0;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: table-driven opcode vectors followed by
// hand-written FIFO full/flush/pause/async-reset sequences.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        reset;
  logic        cal_flg;
  logic [31:0] in_Vj;
  logic [31:0] in_Vk;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [3:0]  in_opcode;
  logic [4:0]  in_dest;
  logic        busy;
  logic        cdb_grant;
  logic        run_upd_alu;
  logic [4:0]  alu_rd;
  logic [31:0] alu_res;
  logic [31:0] alu_target;

  int checks;
  int failures;

  alu_exec_unit #(.ROB_TAG_W(5), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .reset      (reset),
    .cal_flg    (cal_flg),
    .in_Vj      (in_Vj),
    .in_Vk      (in_Vk),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_opcode  (in_opcode),
    .in_dest    (in_dest),
    .busy       (busy),
    .cdb_grant  (cdb_grant),
    .run_upd_alu(run_upd_alu),
    .alu_rd     (alu_rd),
    .alu_res    (alu_res),
    .alu_target (alu_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] exp_res;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] dest);
    cal_flg   = 1'b1;
    in_opcode = op;
    in_Vj     = vj;
    in_Vk     = vk;
    in_imm    = imm;
    in_pc     = pc;
    in_dest   = dest;
  endtask

  task automatic head_is(input string name, input logic [4:0] dest, input logic [31:0] r);
    check({name, ".valid"}, {31'b0, run_upd_alu}, 32'd1);
    check({name, ".rd"},    {27'b0, alu_rd}, {27'b0, dest});
    check({name, ".res"},   alu_res, r);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    rdy       = 1'b1;
    reset     = 1'b0;
    cal_flg   = 1'b0;
    cdb_grant = 1'b0;
    in_Vj     = '0;
    in_Vk     = '0;
    in_imm    = '0;
    in_pc     = '0;
    in_opcode = '0;
    in_dest   = '0;

    vecs[0]  = '{4'd0,  32'h7,        32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFC, 5'd3,  32'h6,         32'h0};
    vecs[1]  = '{4'd1,  32'h5,        32'h7,         32'h0,         32'h200,       5'd4,  32'hFFFF_FFFE, 32'h204};
    vecs[2]  = '{4'd2,  32'h1,        32'h21,        32'h0,         32'h200,       5'd5,  32'h2,         32'h204};
    vecs[3]  = '{4'd3,  32'hFFFF_FFFF,32'h1,         32'h0,         32'h200,       5'd6,  32'h1,         32'h204};
    vecs[4]  = '{4'd4,  32'hFFFF_FFFF,32'h1,         32'h0,         32'h200,       5'd7,  32'h0,         32'h204};
    vecs[5]  = '{4'd5,  32'hF0F0,     32'h0FF0,      32'h0,         32'h200,       5'd8,  32'hFF00,      32'h204};
    vecs[6]  = '{4'd6,  32'h8000_0000,32'h24,        32'h0,         32'h200,       5'd9,  32'h0800_0000, 32'h204};
    vecs[7]  = '{4'd7,  32'h8000_0000,32'h24,        32'h0,         32'h200,       5'd10, 32'hF800_0000, 32'h204};
    vecs[8]  = '{4'd8,  32'h0F00,     32'h00F0,      32'h0,         32'h200,       5'd11, 32'h0FF0,      32'h204};
    vecs[9]  = '{4'd9,  32'hFF00_FF00,32'h0FF0_0FF0, 32'h0,         32'h200,       5'd12, 32'h0F00_0F00, 32'h204};
    vecs[10] = '{4'd10, 32'h5,        32'h6,         32'h4,         32'h100,       5'd13, 32'h0,         32'h104};
    vecs[11] = '{4'd11, 32'h5,        32'h6,         32'h4,         32'h100,       5'd14, 32'h1,         32'h104};
    vecs[12] = '{4'd12, 32'hFFFF_FFFF,32'h1,         32'hFFFF_FFF0, 32'h100,       5'd15, 32'h1,         32'hF0};
    vecs[13] = '{4'd13, 32'hFFFF_FFFF,32'h1,         32'hFFFF_FFF0, 32'h100,       5'd16, 32'h0,         32'hF0};
    vecs[14] = '{4'd14, 32'hFFFF_FFFF,32'h1,         32'hFFFF_FFF0, 32'h100,       5'd17, 32'h0,         32'hF0};
    vecs[15] = '{4'd15, 32'hFFFF_FFFF,32'h1,         32'hFFFF_FFF0, 32'h100,       5'd31, 32'h1,         32'hF0};

    // Reset state
    #3;
    check("rst.valid",  {31'b0, run_upd_alu}, 32'd0);
    check("rst.busy",   {31'b0, busy}, 32'd0);
    check("rst.rd",     {27'b0, alu_rd}, 32'd0);
    check("rst.res",    alu_res, 32'd0);
    check("rst.target", alu_target, 32'd0);
    #9 rst = 1'b1;
    step();

    // Opcode vectors: dispatch into an empty FIFO, check latency-1 broadcast, then pop.
    for (int i = 0; i < 16; i++) begin
      dispatch(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].imm, vecs[i].pc, vecs[i].dest);
      step();
      cal_flg = 1'b0;
      head_is($sformatf("vec%0d", i), vecs[i].dest, vecs[i].exp_res);
      check($sformatf("vec%0d.target", i), alu_target, vecs[i].exp_tgt);
      cdb_grant = 1'b1;
      step();
      cdb_grant = 1'b0;
      check($sformatf("vec%0d.popped", i), {31'b0, run_upd_alu}, 32'd0);
    end

    // Fill to full, ignore dispatch while busy, drain in order.
    dispatch(4'd7, 32'h8000_0000, 32'h24, 32'h0, 32'h0, 5'd1);
    step();
    check("fill1.busy", {31'b0, busy}, 32'd0);
    dispatch(4'd4, 32'h1, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd2);
    step();
    check("fill2.busy", {31'b0, busy}, 32'd1);
    head_is("fill2", 5'd1, 32'hF800_0000);
    dispatch(4'd0, 32'd10, 32'd10, 32'h0, 32'h0, 5'd9);
    step();
    check("busy_ign.busy", {31'b0, busy}, 32'd1);
    head_is("busy_ign", 5'd1, 32'hF800_0000);
    cdb_grant = 1'b1;
    step();
    check("full_grant.busy", {31'b0, busy}, 32'd0);
    head_is("full_grant", 5'd2, 32'd1);
    dispatch(4'd0, 32'd1, 32'd1, 32'h0, 32'h0, 5'd7);
    step();
    cal_flg = 1'b0;
    check("enq_deq.busy", {31'b0, busy}, 32'd0);
    head_is("enq_deq", 5'd7, 32'd2);
    step();
    cdb_grant = 1'b0;
    check("drain.valid", {31'b0, run_upd_alu}, 32'd0);
    check("drain.rd", {27'b0, alu_rd}, 32'd0);

    // Flush with two queued entries and a same-cycle dispatch + grant.
    dispatch(4'd0, 32'd1, 32'd0, 32'h0, 32'h0, 5'd4);
    step();
    dispatch(4'd0, 32'd2, 32'd0, 32'h0, 32'h0, 5'd5);
    step();
    check("pre_flush.busy", {31'b0, busy}, 32'd1);
    dispatch(4'd0, 32'd3, 32'd0, 32'h0, 32'h0, 5'd6);
    reset = 1'b1;
    cdb_grant = 1'b1;
    step();
    reset = 1'b0;
    cal_flg = 1'b0;
    cdb_grant = 1'b0;
    check("flush.valid",  {31'b0, run_upd_alu}, 32'd0);
    check("flush.busy",   {31'b0, busy}, 32'd0);
    check("flush.rd",     {27'b0, alu_rd}, 32'd0);
    check("flush.res",    alu_res, 32'd0);
    check("flush.target", alu_target, 32'd0);
    step();
    check("flush.after", {31'b0, run_upd_alu}, 32'd0);

    // Flush with room in the FIFO: the same-cycle dispatch must still be dropped.
    dispatch(4'd0, 32'd1, 32'd0, 32'h0, 32'h0, 5'd10);
    step();
    dispatch(4'd0, 32'd2, 32'd0, 32'h0, 32'h0, 5'd11);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cal_flg = 1'b0;
    check("flush1.valid", {31'b0, run_upd_alu}, 32'd0);
    step();
    check("flush1.after", {31'b0, run_upd_alu}, 32'd0);

    // Pause: rdy low freezes everything, including flush, grant and dispatch.
    dispatch(4'd0, 32'd3, 32'd4, 32'h0, 32'h40, 5'd8);
    step();
    head_is("pause_pre", 5'd8, 32'd7);
    dispatch(4'd0, 32'd9, 32'd9, 32'h0, 32'h0, 5'd12);
    rdy = 1'b0;
    cdb_grant = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      head_is($sformatf("pause%0d", c), 5'd8, 32'd7);
      check($sformatf("pause%0d.target", c), alu_target, 32'h44);
      check($sformatf("pause%0d.busy", c), {31'b0, busy}, 32'd0);
    end
    rdy = 1'b1;
    cdb_grant = 1'b0;
    reset = 1'b0;
    cal_flg = 1'b0;
    step();
    head_is("resume", 5'd8, 32'd7);
    check("resume.busy", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #3 rst = 1'b0;
    #1;
    check("arst.valid",  {31'b0, run_upd_alu}, 32'd0);
    check("arst.rd",     {27'b0, alu_rd}, 32'd0);
    check("arst.res",    alu_res, 32'd0);
    check("arst.target", alu_target, 32'd0);
    check("arst.busy",   {31'b0, busy}, 32'd0);
    #2 rst = 1'b1;
    step();
    check("arst.after", {31'b0, run_upd_alu}, 32'd0);
    dispatch(4'd1, 32'd0, 32'd1, 32'h0, 32'h0, 5'd13);
    step();
    cal_flg = 1'b0;
    head_is("recover", 5'd13, 32'hFFFF_FFFF);
    check("recover.target", alu_target, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side partner of the reservation station.
- Accepts one dispatched operation per cycle (cal_flg/Vj/Vk/imm/opcode/dest/pc), computes integer ALU or branch-compare results, and buffers them in a small result FIFO.
- Broadcasts results on the ALU CDB port (run_upd_alu/alu_rd/alu_res) under an arbiter grant; those are the signals the RS and ROB snoop.
- Back-pressures the RS with busy.

Parameters:
- ROB_TAG_W, 5, width of ROB tag (dest / alu_rd).
- DEPTH, 2, result FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when low all state holds.
- reset  in  1  branch-mispredict flush, synchronous, active-high.
- cal_flg  in  1  dispatch valid from RS.
- in_Vj  in  32  operand A.
- in_Vk  in  32  operand B (RS has already substituted the immediate for I-type).
- in_imm  in  32  branch offset.
- in_pc  in  32  instruction PC.
- in_opcode  in  4  operation code.
- in_dest  in  ROB_TAG_W  destination ROB tag.
- busy  out  1  FIFO full; RS must not dispatch.
- cdb_grant  in  1  arbiter grants ALU the CDB this cycle.
- run_upd_alu  out  1  CDB result valid.
- alu_rd  out  ROB_TAG_W  tag of broadcast result.
- alu_res  out  32  result; for branches, bit0 = taken, other bits 0.
- alu_target  out  32  pc+imm for branches; pc+4 otherwise.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU.
- Arithmetic:
  - 32-bit wrap-around, no overflow flag.
  - Shift amount = in_Vk[4:0].
  - SLT/BLT/BGE are signed; SLTU/BLTU/BGEU are unsigned.
  - SLT/SLTU produce 0 or 1.
  - alu_target = in_pc + in_imm (wraps) for branches, in_pc + 4 otherwise.
- Enqueue:
  - Condition: cal_flg && !busy && rdy && !reset.
  - Computes result combinationally and writes {dest, res, target} into the FIFO tail at the clock edge.
  - Result is visible on the CDB outputs the next cycle (latency 1 when FIFO empty).
- CDB outputs:
  - Driven directly from the FIFO head.
  - run_upd_alu = (count != 0).
  - alu_rd, alu_res, alu_target hold the head entry while valid; they are 0 when empty.
- Dequeue:
  - Condition: run_upd_alu && cdb_grant && rdy && !reset.
  - Head pointer advances at the edge.
  - Without a grant, the head is held stable, unchanged, over any number of cycles.
- Simultaneous enqueue + dequeue: count unchanged, both pointers advance.
- Counter and pointers:
  - Pointers wrap modulo DEPTH.
  - count ranges 0..DEPTH.
- busy:
  - busy = (count == DEPTH), registered-state-derived with no combinational path from cdb_grant.
  - cal_flg while busy is ignored (no enqueue, no state change).
- Full and empty corners:
  - Full FIFO plus grant: dequeue one; busy deasserts the next cycle.
  - Empty FIFO plus grant: no effect.
- Flush (reset high, rdy high):
  - count, pointers and outputs clear at the edge.
  - Any same-cycle dispatch is dropped.
  - Same-cycle grant is irrelevant; the broadcast in that cycle is still visible combinationally but does not count as dequeued.
- Pause (rdy low):
  - No enqueue, dequeue or flush.
  - Outputs hold their values.
  - Flush is deferred only while rdy is low; it is not latched.
- Priority: rst > !rdy > reset (flush) > enqueue/dequeue.
- Reset (rst low, any time, asynchronous):
  - count = 0, pointers = 0.
  - run_upd_alu = 0, alu_rd = 0, alu_res = 0, alu_target = 0, busy = 0.
  - FIFO contents don't-care.
  - In-flight results are discarded, including mid-operation.

Test Plan:
- Reset then dispatch ADD Vj=7, Vk=0xFFFFFFFF, dest=3 -> next cycle run_upd_alu=1, alu_rd=3, alu_res=6; grant -> run_upd_alu=0 the following cycle.
- Dispatch SRA Vj=0x80000000, Vk=0x24; then SLTU Vj=1, Vk=0xFFFFFFFF; no grant -> busy=1; heads 0xF8000000 then 1 emitted in order as grants arrive; a third cal_flg while busy is ignored.
- BLT Vj=0xFFFFFFFF, Vk=1, pc=0x100, imm=0xFFFFFFF0 -> alu_res=1, alu_target=0xF0; BGEU with same operands -> alu_res=1; BEQ 5,6 -> alu_res=0, alu_target=0x104 when imm=4.
- Full FIFO, same-cycle grant + cal_flg -> dispatch dropped (busy was 1); next cycle busy=0, then enqueue succeeds; with count=1, simultaneous enqueue+grant keeps count=1 and preserves order.
- Two entries queued, assert reset with cal_flg -> next cycle run_upd_alu=0, busy=0; the dropped dispatch never appears.
- rdy=0 for 3 cycles with grant and cal_flg active -> outputs and count frozen. Separately, rst pulsed low mid-cycle -> outputs 0 immediately, before the next clock edge.
